// File: rtl/rvproc_sequencer_pkg.sv
// rvproc_sequencer_pkg: shared state encoding, fault codes and instruction ids for the sequencer.
package rvproc_sequencer_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [3:0] BEQ_OP  = 4'h8;
    localparam logic [3:0] HALT_OP = 4'h9;
    localparam logic [3:0] ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_ILLEGAL = 2'd1,
        FAULT_TIMEOUT = 2'd2
    } fault_e;

endpackage

// File: rtl/rvproc_sequencer_if.sv
// rvproc_sequencer_if: control/status bundle between the sequencer (master) and the core datapath (slave).
interface rvproc_sequencer_if;

    logic        start;
    logic        halt_req;
    logic        imem_ack;
    logic [3:0]  instr_code;
    logic        alu_zero;
    logic        imem_req;
    logic        ir_en;
    logic        pc_en;
    logic        pc_sel;
    logic        rf_wen;
    logic        busy;
    logic        halted;
    logic [1:0]  fault;
    logic [31:0] retired;

    modport master (
        input  start, halt_req, imem_ack, instr_code, alu_zero,
        output imem_req, ir_en, pc_en, pc_sel, rf_wen, busy, halted, fault, retired
    );

    modport slave (
        output start, halt_req, imem_ack, instr_code, alu_zero,
        input  imem_req, ir_en, pc_en, pc_sel, rf_wen, busy, halted, fault, retired
    );

endinterface

// File: rtl/rvproc_fetch_timer.sv
// rvproc_fetch_timer: counts FETCH wait cycles; expired flags the wait cycle that reaches TIMEOUT.
module rvproc_fetch_timer
    import rvproc_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end

    // enable already excludes the ack cycle, so an ack on the last wait cycle wins
    assign expired = enable && cnt == LAST;

endmodule

// File: rtl/rvproc_sequencer.sv
// rvproc_sequencer: steps each instruction through FETCH/DECODE/EXEC/WB, gating PC, IR latch and regfile writes.
// Defining RVPROC_SEQ_PERF_EN builds the 32-bit retired-instruction counter; otherwise retired is tied to 0.
module rvproc_sequencer
    import rvproc_sequencer_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst,
    rvproc_sequencer_if.master bus
);

    logic [2:0] state, state_nx;
    fault_e     fault_q, fault_nx;
    logic       in_fetch, in_wb, is_beq, expired;

    assign in_fetch = state == ST_FETCH;
    assign in_wb    = state == ST_WB;
    assign is_beq   = bus.instr_code == BEQ_OP;

    rvproc_fetch_timer #(.TIMEOUT(IMEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_fetch),
        .enable (in_fetch && !bus.imem_ack),
        .expired(expired)
    );

    always_comb begin
        state_nx = state;
        fault_nx = fault_q;
        case (state)
            ST_IDLE: state_nx = bus.start ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                state_nx = bus.imem_ack ? ST_DECODE : expired ? ST_HALT : ST_FETCH;
                fault_nx = expired ? FAULT_TIMEOUT : fault_q;
            end
            ST_DECODE: begin
                state_nx = (bus.instr_code == ILLEGAL || bus.instr_code == HALT_OP) ? ST_HALT : ST_EXEC;
                fault_nx = bus.instr_code == ILLEGAL ? FAULT_ILLEGAL : fault_q;
            end
            ST_EXEC: state_nx = ST_WB;
            ST_WB: state_nx = bus.halt_req ? ST_HALT : ST_FETCH;
            ST_HALT: begin
                state_nx = bus.start ? ST_FETCH : ST_HALT;
                fault_nx = bus.start ? FAULT_NONE : fault_q;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            fault_q <= FAULT_NONE;
        end else begin
            state   <= state_nx;
            fault_q <= fault_nx;
        end
    end

    assign bus.imem_req = in_fetch;
    assign bus.ir_en    = in_fetch && bus.imem_ack;
    assign bus.pc_en    = in_wb;
    assign bus.pc_sel   = in_wb && is_beq && bus.alu_zero;
    assign bus.rf_wen   = in_wb && !is_beq;
    assign bus.busy     = state != ST_IDLE && state != ST_HALT;
    assign bus.halted   = state == ST_HALT;
    assign bus.fault    = fault_q;

`ifdef RVPROC_SEQ_PERF_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retired_q <= '0;
        else if (in_wb) retired_q <= retired_q + 32'd1;
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = '0;
`endif

endmodule

// File: tb/tb_rvproc_sequencer.sv
// tb_rvproc_sequencer: table-driven cycle vectors plus hand-written reset-abort and latency sequences,
// with expected values queued on a scoreboard and popped at each negedge sample.
module tb_rvproc_sequencer;

`ifdef RVPROC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {imem_req, ir_en, pc_en, pc_sel, rf_wen, busy, halted, fault[1:0]}
    localparam logic [8:0] O_IDLE  = 9'b000000000;
    localparam logic [8:0] O_FACK  = 9'b110001000;
    localparam logic [8:0] O_FWAIT = 9'b100001000;
    localparam logic [8:0] O_BUSY  = 9'b000001000;
    localparam logic [8:0] O_WB    = 9'b001011000;
    localparam logic [8:0] O_BEQT  = 9'b001101000;
    localparam logic [8:0] O_BEQN  = 9'b001001000;
    localparam logic [8:0] O_H0    = 9'b000000100;
    localparam logic [8:0] O_H1    = 9'b000000101;
    localparam logic [8:0] O_H2    = 9'b000000110;

    typedef struct {
        logic        start;
        logic        halt_req;
        logic        imem_ack;
        logic        alu_zero;
        logic [3:0]  code;
        logic [8:0]  outs;
        logic [31:0] ret;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rvproc_sequencer_if bus();

    rvproc_sequencer #(.IMEM_TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vec_t vec[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_ret = 0;
    int   rf_pulses = 0;
    int   pulses_before;
    int   lat;

    always @(negedge clk) if (bus.rf_wen === 1'b1) rf_pulses++;

    function automatic logic [8:0] get_outs();
        return {bus.imem_req, bus.ir_en, bus.pc_en, bus.pc_sel, bus.rf_wen,
                bus.busy, bus.halted, bus.fault};
    endfunction

    task automatic add(input logic s, input logic h, input logic a, input logic [3:0] c,
                       input logic z, input logic [8:0] o);
        vec_t v;
        v.start    = s;
        v.halt_req = h;
        v.imem_ack = a;
        v.code     = c;
        v.alu_zero = z;
        v.outs     = o;
        v.ret      = PERF ? 32'(exp_ret) : 32'd0;
        vec.push_back(v);
        if (o[6]) exp_ret++;
    endtask

    task automatic expect_val(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] got);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%0h", got);
            return;
        end
        e = sb.pop_front();
        if (got !== e.val) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", e.name, got, e.val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // three ALU ops, start while busy is ignored
        add(1, 0, 0, 4'h0, 0, O_IDLE);
        for (int c = 1; c <= 3; c++) begin
            add(0, 0, 1, 4'(c), 0, O_FACK);
            add(0, 0, 0, 4'(c), 0, O_BUSY);
            add(1, 0, 0, 4'(c), 0, O_BUSY);
            add(0, 0, 0, 4'(c), 0, O_WB);
        end
        // BEQ taken, then not taken with halt_req early and halt+start together in WB
        add(0, 0, 1, 4'h8, 0, O_FACK);
        add(0, 0, 0, 4'h8, 0, O_BUSY);
        add(0, 0, 0, 4'h8, 1, O_BUSY);
        add(0, 0, 0, 4'h8, 1, O_BEQT);
        add(0, 0, 1, 4'h8, 0, O_FACK);
        add(0, 1, 0, 4'h8, 0, O_BUSY);
        add(0, 1, 0, 4'h8, 0, O_BUSY);
        add(1, 1, 0, 4'h8, 0, O_BEQN);
        add(0, 0, 0, 4'h0, 0, O_H0);
        add(1, 0, 0, 4'h0, 0, O_H0);
        // fetch timeout after 15 wait cycles
        for (int k = 0; k < 15; k++) add(0, 0, 0, 4'h0, 0, O_FWAIT);
        add(0, 0, 0, 4'h0, 0, O_H2);
        add(1, 0, 0, 4'h0, 0, O_H2);
        // ack on the 15th wait cycle wins, then an illegal instruction
        for (int k = 0; k < 14; k++) add(0, 0, 0, 4'h0, 0, O_FWAIT);
        add(0, 0, 1, 4'hF, 0, O_FACK);
        add(0, 0, 0, 4'hF, 0, O_BUSY);
        add(0, 0, 0, 4'h0, 0, O_H1);
        add(1, 0, 0, 4'h0, 0, O_H1);
        // HALT_OP halts with no fault
        add(0, 0, 1, 4'h9, 0, O_FACK);
        add(0, 0, 0, 4'h9, 0, O_BUSY);
        add(0, 0, 0, 4'h0, 0, O_H0);
        add(1, 0, 0, 4'h0, 0, O_H0);
        // halt_req in EXEC ignored, still high in WB
        add(0, 0, 1, 4'h5, 0, O_FACK);
        add(0, 0, 0, 4'h5, 0, O_BUSY);
        add(0, 1, 0, 4'h5, 0, O_BUSY);
        add(0, 1, 0, 4'h5, 0, O_WB);
        add(0, 0, 0, 4'h0, 0, O_H0);

        bus.start      = 1'b0;
        bus.halt_req   = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.instr_code = 4'h0;
        bus.alu_zero   = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_val("reset_outs", 32'd0);
        check(32'(get_outs()));
        expect_val("reset_retired", 32'd0);
        check(bus.retired);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vec[i]) begin
            bus.start      = vec[i].start;
            bus.halt_req   = vec[i].halt_req;
            bus.imem_ack   = vec[i].imem_ack;
            bus.instr_code = vec[i].code;
            bus.alu_zero   = vec[i].alu_zero;
            expect_val($sformatf("row%0d_outs", i), 32'(vec[i].outs));
            expect_val($sformatf("row%0d_retired", i), vec[i].ret);
            @(negedge clk);
            check(32'(get_outs()));
            check(bus.retired);
            @(posedge clk);
            #1;
        end

        // reset asserted during EXEC aborts the instruction
        bus.start      = 1'b1;
        bus.halt_req   = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.instr_code = 4'h1;
        bus.alu_zero   = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        pulses_before = rf_pulses;
        expect_val("exec_before_abort", 32'(O_BUSY));
        check(32'(get_outs()));
        #2 rst = 1'b0;
        #1;
        expect_val("abort_outs", 32'd0);
        check(32'(get_outs()));
        expect_val("abort_retired", 32'd0);
        check(bus.retired);
        @(posedge clk);
        @(negedge clk);
        expect_val("abort_hold_outs", 32'd0);
        check(32'(get_outs()));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        expect_val("idle_after_release", 32'd0);
        check(32'(get_outs()));
        expect_val("abort_no_rf_wen", 32'(pulses_before));
        check(32'(rf_pulses));

        // start to first rf_wen latency, bounded wait, halt after one instruction
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.halt_req   = 1'b1;
        bus.instr_code = 4'h2;
        bus.imem_ack   = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        expect_val("start_to_rf_wen_cycles", 32'd4);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rf_wen && lat == 0) lat = k;
        end
        check(32'(lat));
        expect_val("halt_after_wb", 32'(O_H0));
        check(32'(get_outs()));
        expect_val("retired_after_one", PERF ? 32'd1 : 32'd0);
        check(bus.retired);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
